risc_dbg_ctrl: RTL

//  Debug/step controller beside the Risc32 core. Accepts host commands to poke IM/DM/regfile, set PC,
//  run the core for N clock-enabled cycles and peek registers. Replaces bench-side hierarchical pokes

---
 rtl/risc_dbg_pkg.sv | 38 +++
 rtl/risc_dbg_run_cnt.sv | 45 ++++
 rtl/risc_dbg_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/risc_dbg_pkg.sv
// Shared encodings and default widths for the Risc32 debug/step controller.
// No logic of its own; imported by the controller and its run counter.
// Command opcodes and FSM states live here so host code and RTL agree.
package risc_dbg_pkg;

    localparam int DBG_DATA_W = 32;
    localparam int DBG_REG_AW = 3;
    localparam int DBG_IM_AW  = 8;
    localparam int DBG_DM_AW  = 5;
    localparam int DBG_RUN_W  = 16;
    localparam int DBG_CYC_W  = 32;

    // Host command opcodes; code 7 is unassigned and behaves like NOP.
    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_POKE_IM  = 3'd1,
        OP_POKE_DM  = 3'd2,
        OP_POKE_REG = 3'd3,
        OP_SET_PC   = 3'd4,
        OP_RUN      = 3'd5,
        OP_PEEK_REG = 3'd6
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RUN   = 3'd2,
        ST_PEEK  = 3'd3,
        ST_RESP  = 3'd4
    } dbg_state_e;

    // True for the four single-cycle write commands.
    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_POKE_IM) || (op == OP_POKE_DM) ||
               (op == OP_POKE_REG) || (op == OP_SET_PC);
    endfunction

endpackage

// File: rtl/risc_dbg_run_cnt.sv
// Loadable down-counter that meters RUN cycles; flags zero and last-count.
// Latency: load/dec/abort take effect at the next clock edge.
// No backpressure: abort has priority over load, load over decrement.
module risc_dbg_run_cnt
    import risc_dbg_pkg::*;
#(
    parameter int W = DBG_RUN_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    input  logic         abort_i,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: abort clears, load replaces, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (abort_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/risc_dbg_ctrl.sv
// Debug/step controller: pokes IM/DM/regfile/PC, runs the core N cycles, peeks registers.
// Latency accept->rsp_valid: 1 (NOP, RUN 0), 2 (pokes, PEEK), N+1 (RUN N, fewer on halt).
// One command in flight: cmd_ready drops from accept until the response cycle has passed.
// Optional build macro STEP_CHECK_EN: PEEK compares the register against cmd_data and flags rsp_err.
module risc_dbg_ctrl
    import risc_dbg_pkg::*;
#(
    parameter int DATA_W = DBG_DATA_W,
    parameter int REG_AW = DBG_REG_AW,
    parameter int IM_AW  = DBG_IM_AW,
    parameter int DM_AW  = DBG_DM_AW,
    parameter int RUN_W  = DBG_RUN_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [DATA_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic              halt_req_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              cpu_en_o,
    output logic              pc_wr_en_o,
    output logic [DATA_W-1:0] pc_wr_data_o,
    output logic              im_wr_en_o,
    output logic [IM_AW-1:0]  im_wr_addr_o,
    output logic [DATA_W-1:0] im_wr_data_o,
    output logic              dm_wr_en_o,
    output logic [DM_AW-1:0]  dm_wr_addr_o,
    output logic [DATA_W-1:0] dm_wr_data_o,
    output logic              rf_wr_en_o,
    output logic [REG_AW-1:0] rf_wr_addr_o,
    output logic [DATA_W-1:0] rf_wr_data_o,
    output logic [REG_AW-1:0] rf_rd_addr_o,
    input  logic [DATA_W-1:0] rf_rd_data_i,
    output logic [31:0]       cycle_count_o
);

    dbg_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [31:0]       cyc_q, cyc_d;

    logic cmd_acc;
    logic run_load, run_dec, run_abort;
    logic run_zero, run_last;
    logic cpu_en;

    // Reset forces ready low so a command presented during reset is never taken.
    assign cmd_ready_o = (state_q == ST_IDLE) && !reset_i;
    assign cmd_acc     = cmd_valid_i && cmd_ready_o;

    risc_dbg_run_cnt #(
        .W (RUN_W)
    ) u_run_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (run_load),
        .load_val_i (cmd_data_i[RUN_W-1:0]),
        .dec_i      (run_dec),
        .abort_i    (run_abort),
        .zero_o     (run_zero),
        .last_o     (run_last)
    );

    // FSM next state and run-counter controls; cpu_en only ever asserted in RUN.
    always_comb begin
        state_d   = state_q;
        run_load  = 1'b0;
        run_dec   = 1'b0;
        run_abort = 1'b0;
        cpu_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    if (is_write_op(cmd_op_i)) begin
                        state_d = ST_WRITE;
                    end else if (cmd_op_i == OP_RUN) begin
                        run_load = 1'b1;
                        // A zero count skips the core entirely.
                        state_d  = (cmd_data_i[RUN_W-1:0] == '0) ? ST_RESP : ST_RUN;
                    end else if (cmd_op_i == OP_PEEK_REG) begin
                        state_d = ST_PEEK;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RUN: begin
                // This cycle is always an enabled core cycle; halt only stops the next one.
                cpu_en  = 1'b1;
                run_dec = 1'b1;
                if (halt_req_i) begin
                    run_abort = 1'b1;
                    state_d   = ST_RESP;
                end else if (run_last || run_zero) begin
                    state_d = ST_RESP;
                end
            end
            ST_PEEK: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture at accept, PEEK result capture, and the enabled-cycle counter.
    always_comb begin
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        cyc_d      = cpu_en ? (cyc_q + 32'd1) : cyc_q;
        if (cmd_acc) begin
            op_d       = cmd_op_i;
            addr_d     = cmd_addr_i;
            data_d     = cmd_data_i;
            rsp_data_d = '0;
        end else if (state_q == ST_PEEK) begin
            rsp_data_d = rf_rd_data_i;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q       <= 3'd0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            cyc_q      <= '0;
        end else begin
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            cyc_q      <= cyc_d;
        end
    end

    // Exactly one write strobe in the WRITE cycle, selected by the latched opcode.
    always_comb begin
        im_wr_en_o = 1'b0;
        dm_wr_en_o = 1'b0;
        rf_wr_en_o = 1'b0;
        pc_wr_en_o = 1'b0;
        if (state_q == ST_WRITE) begin
            case (op_q)
                OP_POKE_IM:  im_wr_en_o = 1'b1;
                OP_POKE_DM:  dm_wr_en_o = 1'b1;
                OP_POKE_REG: rf_wr_en_o = 1'b1;
                OP_SET_PC:   pc_wr_en_o = 1'b1;
                default: ;
            endcase
        end
    end

    // Byte addresses become word indices; upper bits wrap silently.
    assign im_wr_addr_o = addr_q[IM_AW+1:2];
    assign dm_wr_addr_o = addr_q[DM_AW+1:2];
    assign rf_wr_addr_o = addr_q[REG_AW-1:0];
    assign im_wr_data_o = data_q;
    assign dm_wr_data_o = data_q;
    assign rf_wr_data_o = data_q;
    assign pc_wr_data_o = addr_q;

    // Read address follows the live command while idle so the regfile settles before PEEK.
    assign rf_rd_addr_o = (state_q == ST_IDLE) ? cmd_addr_i[REG_AW-1:0] : addr_q[REG_AW-1:0];

    assign cpu_en_o      = cpu_en;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_data_o    = (state_q == ST_RESP) ? rsp_data_q : '0;
    assign cycle_count_o = cyc_q;

`ifdef STEP_CHECK_EN
    logic err_q, err_d;

    // Compare the peeked register against the expectation captured with the command.
    always_comb begin
        err_d = err_q;
        if (cmd_acc) begin
            err_d = 1'b0;
        end else if (state_q == ST_PEEK) begin
            err_d = (rf_rd_data_i != data_q);
        end
    end

    // Mismatch flag register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rsp_err_o = (state_q == ST_RESP) && err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule
